uctrl_port_arbiter: RTL and testbench
=====================================

// Module: uctrl_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port memory/register-bank port among
//  NREQ requesters in uctrl: 8051 core, boot loader, crypto engine.
//  Grant is registered and held until the owner releases it.
//  The shared port is driven by a mux steered by the registered owner.
//  Sits between the requesters and the storage built from the cell-library flops.
// PARAMETERS
//  NREQ      3   number of requesters (2..8)
//  AW        16  address width
//  DW        8   data width
//  HOLD_MAX  15  max grant length in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  CK         in   1        clock, rising edge
//  RN         in   1        async active-low reset
//  req        in   NREQ     per-requester request, held high for the whole transfer
//  last       in   NREQ     per-requester final-beat flag, sampled with req
//  req_addr   in   NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW  flattened write data
//  req_we     in   NREQ     per-requester write enable
//  gnt        out  NREQ     one-hot grant, registered
//  mem_en     out  1        shared-port enable
//  mem_we     out  1        shared-port write enable
//  mem_addr   out  AW       shared-port address
//  mem_wdata  out  DW       shared-port write data
//  owner      out  3        index of current owner; valid while busy
//  busy       out  1        a grant is active
//  timeout_err out 1        1-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//  Reset (RN low, async): state IDLE, gnt=0, busy=0, owner=0, rr_ptr=0,
//   mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_err=0.
//   RN low mid-transfer drops the grant immediately. No beat completes after reset.
//  FSM has three states: IDLE, GRANT, GAP.
//   IDLE: when |req, pick the first set req at or above rr_ptr, wrapping.
//    Next edge: gnt[pick]=1, owner=pick, busy=1, state GRANT.
//    Latency from req rise to gnt is 1 cycle.
//   GRANT: mem_en = req[owner]. mem_we/addr/wdata = owner's inputs, combinational mux.
//    Release when req[owner]&last[owner] (beat still performed that cycle)
//    or when req[owner] drops (no beat that cycle).
//    Release edge: gnt=0, busy=0, rr_ptr=owner+1 mod NREQ, state GAP.
//   GAP: one idle cycle with mem_en=0, then IDLE. No back-to-back grants.
//  Outside GRANT, mem_en and mem_we are 0; addr/wdata hold the last value.
//  Simultaneous requests: the rotating pointer decides.
//   A requester just released has lowest priority next round.
//  Requests from non-owners during GRANT are ignored; they stay pending.
//  A single requester always wins, regardless of rr_ptr.
//  gnt is always one-hot or zero. owner never changes inside GRANT.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - hold counter (4+ bits) clears on grant and increments each GRANT cycle.
//   - When the counter reaches HOLD_MAX without release: force release that
//     edge, pulse timeout_err for 1 cycle, advance rr_ptr past the owner.
//  ARB_TIMEOUT_EN undefined: no counter, timeout_err tied 0, grant unbounded.
// STRUCTURE
//  Shared package uctrl_arb_pkg:
//   - state encoding ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2;
//   - OWNER_W=3;
//   - function onehot(idx).
//  Sub-module uctrl_rr_pick (combinational): req, rr_ptr -> pick index + valid.
//  Top holds the FSM, owner/rr_ptr registers, port mux and optional counter.
// TESTING
//  1 Reset: RN low with req=3'b111 -> gnt=0, mem_en=0, busy=0; after RN high,
//    gnt=3'b001 one cycle later.
//  2 Rotation: req=3'b111 held, each owner gives a 2-beat burst with last on
//    beat 2 -> grant order 0,1,2,0 with one GAP cycle between grants.
//  3 Mux: owner 1 drives addr=16'h00A5, wdata=8'h3C, we=1 ->
//    mem_addr=16'h00A5, mem_wdata=8'h3C, mem_we=1, mem_en=1 in the same cycle.
//  4 Drop: owner deasserts req mid-burst with no last -> gnt=0 next edge,
//    mem_en=0 that cycle, rr_ptr=owner+1.
//  5 Async reset mid-GRANT: RN pulsed low -> gnt=0 with no CK edge;
//    rr_ptr=0 afterwards.
//  6 (ARB_TIMEOUT_EN) req[2] held with no last, HOLD_MAX=15 ->
//    forced release after 15 GRANT cycles, timeout_err=1 for one cycle,
//    next grant goes to 0.

Source files
------------

// File: rtl/uctrl_arb_pkg.sv
// Shared types for the uctrl port arbiter.
// State encoding, owner index width and a one-hot helper.
package uctrl_arb_pkg;

    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arbState_e;

    function automatic logic [7:0] onehot(input logic [OWNER_W-1:0] idx);
        onehot = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/uctrl_port_arbiter_if.sv
// Requester bundle plus shared memory port of the uctrl port arbiter.
// master = requester/bench side, slave = arbiter side.
interface uctrl_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    import uctrl_arb_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    last;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_we;

    logic [NREQ-1:0]    gnt;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req, last, req_addr, req_wdata, req_we,
        input  gnt, mem_en, mem_we, mem_addr, mem_wdata,
        input  owner, busy, timeout_err
    );

    modport slave (
        input  req, last, req_addr, req_wdata, req_we,
        output gnt, mem_en, mem_we, mem_addr, mem_wdata,
        output owner, busy, timeout_err
    );

endinterface

// File: rtl/uctrl_rr_pick.sv
// Round-robin picker: first set request at or above rrPtr, wrapping.
// Purely combinational.
module uctrl_rr_pick
    import uctrl_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] rrPtr,
    output logic [OWNER_W-1:0] pick,
    output logic               valid
);

    // upper pass from rrPtr, then wrap to the lowest set request
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (OWNER_W'(i) >= rrPtr)) begin
                valid = 1'b1;
                pick  = OWNER_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i]) begin
                valid = 1'b1;
                pick  = OWNER_W'(i);
            end
        end
    end

endmodule

// File: rtl/uctrl_port_arbiter.sv
// Round-robin owner of the shared uctrl memory port.
// Optional grant timeout: define ARB_TIMEOUT_EN.
module uctrl_port_arbiter
    import uctrl_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 15
) (
    input logic               CK,
    input logic               RN,
    uctrl_port_arbiter_if.slave bus
);

    arbState_e          state;
    logic [OWNER_W-1:0] rrPtr;
    logic [OWNER_W-1:0] ownerQ;
    logic [OWNER_W-1:0] nextPtr;
    logic [OWNER_W-1:0] pick;
    logic               pickValid;
    logic [NREQ-1:0]    gntQ;
    logic               busyQ;
    logic [AW-1:0]      addrQ;
    logic [DW-1:0]      wdataQ;

    logic               ownReq;
    logic               ownLast;
    logic               ownWe;
    logic [AW-1:0]      ownAddr;
    logic [DW-1:0]      ownWdata;
    logic               inGrant;
    logic               relGrant;
    logic               tmoFire;

    uctrl_rr_pick #(.NREQ(NREQ)) uPick (
        .req   (bus.req),
        .rrPtr (rrPtr),
        .pick  (pick),
        .valid (pickValid)
    );

    // select the current owner's request lines
    always_comb begin
        ownReq   = 1'b0;
        ownLast  = 1'b0;
        ownWe    = 1'b0;
        ownAddr  = '0;
        ownWdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ownerQ == OWNER_W'(i)) begin
                ownReq   = bus.req[i];
                ownLast  = bus.last[i];
                ownWe    = bus.req_we[i];
                ownAddr  = bus.req_addr[i*AW +: AW];
                ownWdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    assign inGrant  = (state == ST_GRANT);
    assign relGrant = inGrant & (~ownReq | ownLast | tmoFire);
    assign nextPtr  = (ownerQ == OWNER_W'(NREQ - 1)) ? '0 : ownerQ + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int CWRAW = $clog2(HOLD_MAX + 1);
    localparam int CW    = (CWRAW < 4) ? 4 : CWRAW;

    logic [CW-1:0] holdCnt;
    logic          timeoutErrQ;

    assign tmoFire = inGrant & ownReq & ~ownLast &
                     (holdCnt == CW'(HOLD_MAX - 1));

    // count cycles spent in GRANT, cleared while waiting for a grant
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            holdCnt     <= '0;
            timeoutErrQ <= 1'b0;
        end else begin
            timeoutErrQ <= tmoFire;
            if (inGrant) holdCnt <= holdCnt + 1'b1;
            else         holdCnt <= '0;
        end
    end

    assign bus.timeout_err = timeoutErrQ;
`else
    assign tmoFire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // arbitration FSM with registered grant, owner and pointer
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= ST_IDLE;
            gntQ   <= '0;
            busyQ  <= 1'b0;
            ownerQ <= '0;
            rrPtr  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pickValid) begin
                        gntQ   <= NREQ'(onehot(pick));
                        ownerQ <= pick;
                        busyQ  <= 1'b1;
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (relGrant) begin
                        gntQ  <= '0;
                        busyQ <= 1'b0;
                        rrPtr <= nextPtr;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // remember the last driven address/data so the port holds it when idle
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            addrQ  <= '0;
            wdataQ <= '0;
        end else if (inGrant) begin
            addrQ  <= ownAddr;
            wdataQ <= ownWdata;
        end
    end

    assign bus.gnt       = gntQ;
    assign bus.busy      = busyQ;
    assign bus.owner     = ownerQ;
    assign bus.mem_en    = inGrant & ownReq;
    assign bus.mem_we    = inGrant & ownWe;
    assign bus.mem_addr  = inGrant ? ownAddr : addrQ;
    assign bus.mem_wdata = inGrant ? ownWdata : wdataQ;

endmodule

// File: tb/tb_uctrl_port_arbiter.sv
// Directed bench for uctrl_port_arbiter.
// Covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_uctrl_port_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 8;

    typedef struct {
        logic [2:0] req;
        logic [2:0] last;
        logic [2:0] expGnt;
        logic       expBusy;
        logic       expEn;
        logic       expWe;
        logic [2:0] expOwner;
    } vec_t;

    logic clk;
    logic rn;
    int   nChecks;
    int   nErr;

    logic [AW-1:0] addrTab [3];
    logic [DW-1:0] wdTab   [3];
    vec_t          vecs    [32];

    uctrl_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    uctrl_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .HOLD_MAX(15)
    ) dut (
        .CK  (clk),
        .RN  (rn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] last,
                                input logic [2:0] g, input logic b,
                                input logic en, input logic we,
                                input logic [2:0] own);
        vec_t v;
        v.req = req; v.last = last; v.expGnt = g; v.expBusy = b;
        v.expEn = en; v.expWe = we; v.expOwner = own;
        return v;
    endfunction

    initial begin
        int cnt;
        nChecks = 0;
        nErr    = 0;
        addrTab[0] = 16'h1234; addrTab[1] = 16'h00A5; addrTab[2] = 16'hBEEF;
        wdTab[0]   = 8'h11;    wdTab[1]   = 8'h3C;    wdTab[2]   = 8'h5A;

        // rotation with 2-beat bursts, GAP between grants
        vecs[0]  = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[1]  = mk(3'b111, 3'b000, 3'b001, 1, 1, 0, 0);
        vecs[2]  = mk(3'b111, 3'b001, 3'b001, 1, 1, 0, 0);
        vecs[3]  = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[4]  = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[5]  = mk(3'b111, 3'b000, 3'b010, 1, 1, 1, 1);
        vecs[6]  = mk(3'b111, 3'b010, 3'b010, 1, 1, 1, 1);
        vecs[7]  = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[8]  = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[9]  = mk(3'b111, 3'b000, 3'b100, 1, 1, 0, 2);
        vecs[10] = mk(3'b111, 3'b100, 3'b100, 1, 1, 0, 2);
        vecs[11] = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[12] = mk(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[13] = mk(3'b111, 3'b000, 3'b001, 1, 1, 0, 0);
        vecs[14] = mk(3'b111, 3'b001, 3'b001, 1, 1, 0, 0);
        vecs[15] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[16] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        // single requester wins although pointer is at 1
        vecs[17] = mk(3'b001, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[18] = mk(3'b001, 3'b001, 3'b001, 1, 1, 0, 0);
        vecs[19] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        // owner 1 mux, then drop without last
        vecs[20] = mk(3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[21] = mk(3'b010, 3'b000, 3'b010, 1, 1, 1, 1);
        vecs[22] = mk(3'b010, 3'b000, 3'b010, 1, 1, 1, 1);
        vecs[23] = mk(3'b000, 3'b000, 3'b010, 1, 0, 0, 1);
        vecs[24] = mk(3'b011, 3'b000, 3'b000, 0, 0, 0, 0);
        // pointer now 2: 0 wins over 1
        vecs[25] = mk(3'b011, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[26] = mk(3'b011, 3'b001, 3'b001, 1, 1, 0, 0);
        vecs[27] = mk(3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[28] = mk(3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[29] = mk(3'b010, 3'b010, 3'b010, 1, 1, 1, 1);
        vecs[30] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        vecs[31] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);

        rn            = 1'b0;
        bus.req       = 3'b111;
        bus.last      = 3'b000;
        bus.req_we    = 3'b010;
        bus.req_addr  = {addrTab[2], addrTab[1], addrTab[0]};
        bus.req_wdata = {wdTab[2], wdTab[1], wdTab[0]};

        // reset held with all requests pending
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_en", 32'(bus.mem_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_tmo", 32'(bus.timeout_err), 0);
        rn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_first_gnt", 32'(bus.gnt), 32'b001);

        // restart from a clean IDLE for the table
        rn = 1'b0;
        @(negedge clk);
        rn = 1'b1;

        for (int i = 0; i < 32; i++) begin
            bus.req  = vecs[i].req;
            bus.last = vecs[i].last;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].expGnt));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
            chk($sformatf("v%0d_en", i), 32'(bus.mem_en), 32'(vecs[i].expEn));
            if (vecs[i].expBusy)
                chk($sformatf("v%0d_owner", i), 32'(bus.owner),
                    32'(vecs[i].expOwner));
            if (vecs[i].expEn) begin
                chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].expWe));
                chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr),
                    32'(addrTab[vecs[i].expOwner]));
                chk($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata),
                    32'(wdTab[vecs[i].expOwner]));
            end
            @(negedge clk);
        end

        // port holds last owner's address/data while idle
        #1;
        chk("hold_addr", 32'(bus.mem_addr), 32'h00A5);
        chk("hold_wdata", 32'(bus.mem_wdata), 32'h3C);
        chk("hold_we", 32'(bus.mem_we), 0);

        // async reset in the middle of a grant
        bus.req  = 3'b100;
        bus.last = 3'b000;
        @(negedge clk);
        #1;
        chk("ar_gnt_before", 32'(bus.gnt), 32'b100);
        #2;
        rn = 1'b0;
        #1;
        chk("ar_gnt", 32'(bus.gnt), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_en", 32'(bus.mem_en), 0);
        @(negedge clk);
        rn      = 1'b1;
        bus.req = 3'b110;
        @(negedge clk);
        #1;
        chk("ar_ptr0_gnt", 32'(bus.gnt), 32'b010);
        bus.last = 3'b010;
        @(negedge clk);
        bus.req  = 3'b000;
        bus.last = 3'b000;
        #1;
        chk("ar_gap_gnt", 32'(bus.gnt), 0);
        @(negedge clk);

        // long hold by requester 2, requester 0 waiting
        bus.req = 3'b101;
        cnt     = 0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.gnt == 3'b100) cnt++;
            else if (cnt > 0) break;
        end
        chk("tmo_len", 32'(cnt), 15);
        chk("tmo_pulse", 32'(bus.timeout_err), 1);
        chk("tmo_gap_gnt", 32'(bus.gnt), 0);
        @(negedge clk);
        #1;
        chk("tmo_pulse_end", 32'(bus.timeout_err), 0);
        @(negedge clk);
        #1;
        chk("tmo_next_gnt", 32'(bus.gnt), 32'b001);
`else
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            #1;
            if (bus.gnt == 3'b100) cnt++;
            if (bus.timeout_err !== 1'b0) cnt = -100;
        end
        chk("hold_unbounded", 32'(cnt), 25);
`endif
        bus.req = 3'b000;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule
